// File: rtl/otter_intr_ctrl_pkg.sv
// rtl/otter_intr_ctrl_pkg.sv - shared types and defaults for the OTTER interrupt controller
package otter_intc_pkg;

    localparam int INTC_NUM_SRC     = 4;
    localparam int INTC_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        INTC_IDLE,
        INTC_REQ,
        INTC_SERVICE
    } intc_state_t;

    // A single source still needs a one-bit cause field.
    function automatic int intc_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/otter_intr_ctrl_if.sv
// rtl/otter_intr_ctrl_if.sv - CSR/FSM-facing signal bundle of the interrupt controller
interface otter_intr_ctrl_if
    import otter_intc_pkg::*;
#(
    parameter int NUM_SRC = INTC_NUM_SRC
);
    localparam int ID_W = intc_id_w(NUM_SRC);

    logic [NUM_SRC-1:0] irq_src;
    logic [NUM_SRC-1:0] irq_en;
    logic               glb_ie;
    logic [NUM_SRC-1:0] pend_clr;
    logic               int_taken;
    logic               mret_exec;
    logic               intr_out;
    logic [ID_W-1:0]    cause_id;
    logic               cause_valid;
    logic [NUM_SRC-1:0] pending;

    modport master (
        output irq_src, irq_en, glb_ie, pend_clr, int_taken, mret_exec,
        input  intr_out, cause_id, cause_valid, pending
    );

    modport slave (
        input  irq_src, irq_en, glb_ie, pend_clr, int_taken, mret_exec,
        output intr_out, cause_id, cause_valid, pending
    );

endinterface

// File: rtl/otter_intr_ctrl_sync_edge.sv
// rtl/otter_intr_ctrl_sync_edge.sv - per-source synchronizer with rising-edge detect
module intc_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic irq,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/otter_intr_ctrl.sv
// rtl/otter_intr_ctrl.sv - fixed-priority, non-nesting interrupt controller for the OTTER FSM
module otter_intr_ctrl
    import otter_intc_pkg::*;
#(
    parameter int NUM_SRC     = INTC_NUM_SRC,
    parameter int SYNC_STAGES = INTC_SYNC_STAGES
) (
    input  logic              INTC_clk,
    input  logic              INTC_RSTn,
    otter_intr_ctrl_if.slave  bus
);
    localparam int ID_W = intc_id_w(NUM_SRC);

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] clr_win;
    logic [NUM_SRC-1:0] pend_q;
    logic [ID_W-1:0]    cause_q;
    logic [ID_W-1:0]    winner;
    intc_state_t        state;
    intc_state_t        state_nxt;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        intc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk    (INTC_clk),
            .resetn (INTC_RSTn),
            .irq    (bus.irq_src[g]),
            .rise   (rise[g])
        );
    end

    // Index 0 is highest priority: scan downward so the lowest set bit wins.
    function automatic logic [ID_W-1:0] prio_pick(input logic [NUM_SRC-1:0] v);
        prio_pick = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) prio_pick = ID_W'(i);
        end
    endfunction

    assign eligible = pend_q & bus.irq_en;
    assign winner   = prio_pick(eligible);

    always_comb begin
        state_nxt = state;
        clr_win   = '0;
        case (state)
            INTC_IDLE: begin
                if (bus.glb_ie && |eligible) state_nxt = INTC_REQ;
            end
            INTC_REQ: begin
                if (bus.int_taken) begin
                    state_nxt        = INTC_SERVICE;
                    clr_win[cause_q] = 1'b1;
                end else if (!bus.glb_ie || !bus.irq_en[cause_q] || !pend_q[cause_q]) begin
                    state_nxt = INTC_IDLE;
                end
            end
            INTC_SERVICE: begin
                if (bus.mret_exec) state_nxt = INTC_IDLE;
            end
            default: state_nxt = INTC_IDLE;
        endcase
    end

    // A fresh edge always re-sets pending, even against a clear in the same cycle.
    always_ff @(posedge INTC_clk) begin
        if (!INTC_RSTn) begin
            state   <= INTC_IDLE;
            pend_q  <= '0;
            cause_q <= '0;
        end else begin
            state  <= state_nxt;
            pend_q <= (pend_q & ~bus.pend_clr & ~clr_win) | rise;
            if (state == INTC_IDLE && state_nxt == INTC_REQ) cause_q <= winner;
        end
    end

    assign bus.intr_out    = (state == INTC_REQ);
    assign bus.cause_valid = (state != INTC_IDLE);
    assign bus.cause_id    = (NUM_SRC == 1) ? '0 : cause_q;
    assign bus.pending     = pend_q;

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// tb/tb_otter_intr_ctrl.sv - self-checking bench for otter_intr_ctrl
module tb_otter_intr_ctrl;
    import otter_intc_pkg::*;

    localparam int N    = 4;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] irq, en, clr;
    logic       gie, taken, mret;

    always #5 clk = ~clk;

    otter_intr_ctrl_if #(.NUM_SRC(N)) bus ();

    assign bus.irq_src   = irq;
    assign bus.irq_en    = en;
    assign bus.glb_ie    = gie;
    assign bus.pend_clr  = clr;
    assign bus.int_taken = taken;
    assign bus.mret_exec = mret;

    otter_intr_ctrl #(.NUM_SRC(N), .SYNC_STAGES(SYNC)) dut (
        .INTC_clk  (clk),
        .INTC_RSTn (rstn),
        .bus       (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: irq samples seen at past clock edges, plus a mode/cause/pending record.
    logic [3:0] hist [0:3];
    int         m_mode;     // 0 idle, 1 requesting, 2 in service
    int         m_cause;
    logic [3:0] m_pend;

    typedef struct {
        logic [3:0] irq;
        logic       taken;
        logic       mret;
        logic       e_intr;
        logic       e_valid;
        logic [1:0] e_cause;
        logic [3:0] e_pend;
    } vec_t;

    vec_t tbl [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic step();
        logic [3:0] rise, cl, np;
        int nm, nc;
        // A level change becomes a pending bit SYNC_STAGES edges after it is first sampled.
        rise = hist[SYNC-1] & ~hist[SYNC];
        cl   = '0;
        nm   = m_mode;
        nc   = m_cause;
        case (m_mode)
            0: if (gie && (m_pend & en) != 0) begin
                   nm = 1;
                   nc = lowest(m_pend & en);
               end
            1: if (taken) begin
                   nm = 2;
                   cl[m_cause] = 1'b1;
               end else if (!gie || !en[m_cause] || !m_pend[m_cause]) begin
                   nm = 0;
               end
            default: if (mret) nm = 0;
        endcase
        np = (m_pend & ~clr & ~cl) | rise;
        @(posedge clk);
        if (!rstn) begin
            m_mode = 0; m_cause = 0; m_pend = '0;
            for (int i = 0; i < 4; i++) hist[i] = '0;
        end else begin
            m_mode = nm; m_cause = nc; m_pend = np;
            for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = irq;
        end
        #1;
        check("model_intr_out",    {31'd0, bus.intr_out},    {31'd0, m_mode == 1});
        check("model_cause_valid", {31'd0, bus.cause_valid}, {31'd0, m_mode != 0});
        check("model_cause_id",    {30'd0, bus.cause_id},    m_cause);
        check("model_pending",     {28'd0, bus.pending},     {28'd0, m_pend});
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rstn = 1'b0; irq = '0; clr = '0; taken = 1'b0; mret = 1'b0;
        hold(2);
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0; irq = 4'hF; en = 4'hF; gie = 1'b0; clr = '0; taken = 1'b0; mret = 1'b0;
        m_mode = 0; m_cause = 0; m_pend = '0;
        for (int i = 0; i < 4; i++) hist[i] = '0;

        // Reset with every source high.
        hold(3);
        check("rst_intr_out", {31'd0, bus.intr_out}, 32'd0);
        check("rst_cause_valid", {31'd0, bus.cause_valid}, 32'd0);
        check("rst_pending", {28'd0, bus.pending}, 32'd0);
        rstn = 1'b1;
        hold(4);
        check("post_rst_no_req", {31'd0, bus.intr_out}, 32'd0);

        // Directed table: single source, then priority with back-to-back service.
        tbl[0]  = '{4'h0, 0, 0, 0, 0, 2'd0, 4'h0};
        tbl[1]  = '{4'h4, 0, 0, 0, 0, 2'd0, 4'h0};
        tbl[2]  = '{4'h4, 0, 0, 0, 0, 2'd0, 4'h0};
        tbl[3]  = '{4'h4, 0, 0, 0, 0, 2'd0, 4'h4};
        tbl[4]  = '{4'h4, 0, 0, 1, 1, 2'd2, 4'h4};
        tbl[5]  = '{4'h4, 0, 0, 1, 1, 2'd2, 4'h4};
        tbl[6]  = '{4'h4, 1, 0, 0, 1, 2'd2, 4'h0};
        tbl[7]  = '{4'h4, 0, 0, 0, 1, 2'd2, 4'h0};
        tbl[8]  = '{4'h4, 0, 1, 0, 0, 2'd2, 4'h0};
        tbl[9]  = '{4'h4, 0, 0, 0, 0, 2'd2, 4'h0};
        tbl[10] = '{4'hE, 0, 0, 0, 0, 2'd2, 4'h0};
        tbl[11] = '{4'hE, 0, 0, 0, 0, 2'd2, 4'h0};
        tbl[12] = '{4'hE, 0, 0, 0, 0, 2'd2, 4'hA};
        tbl[13] = '{4'hE, 0, 0, 1, 1, 2'd1, 4'hA};
        tbl[14] = '{4'hE, 1, 0, 0, 1, 2'd1, 4'h8};
        tbl[15] = '{4'hE, 0, 1, 0, 0, 2'd1, 4'h8};
        tbl[16] = '{4'hE, 0, 0, 1, 1, 2'd3, 4'h8};
        tbl[17] = '{4'h0, 1, 0, 0, 1, 2'd3, 4'h0};
        tbl[18] = '{4'h0, 0, 1, 0, 0, 2'd3, 4'h0};

        gie = 1'b0;
        do_reset();
        gie = 1'b1; en = 4'hF;
        for (int r = 0; r < 19; r++) begin
            irq = tbl[r].irq; taken = tbl[r].taken; mret = tbl[r].mret;
            step();
            check($sformatf("tbl%0d_intr", r),  {31'd0, bus.intr_out},    {31'd0, tbl[r].e_intr});
            check($sformatf("tbl%0d_valid", r), {31'd0, bus.cause_valid}, {31'd0, tbl[r].e_valid});
            check($sformatf("tbl%0d_cause", r), {30'd0, bus.cause_id},    {30'd0, tbl[r].e_cause});
            check($sformatf("tbl%0d_pend", r),  {28'd0, bus.pending},     {28'd0, tbl[r].e_pend});
        end
        taken = 1'b0; mret = 1'b0;

        // No preemption: source 0 arrives while source 2 is requesting.
        do_reset();
        irq = 4'h4; hold(4);
        irq = 4'h5; hold(4);
        check("nopre_cause", {30'd0, bus.cause_id}, 32'd2);
        check("nopre_intr", {31'd0, bus.intr_out}, 32'd1);
        taken = 1'b1; step(); taken = 1'b0;
        check("nopre_pend0", {31'd0, bus.pending[0]}, 32'd1);
        mret = 1'b1; step(); mret = 1'b0; step();
        check("nopre_next_cause", {30'd0, bus.cause_id}, 32'd0);
        check("nopre_next_intr", {31'd0, bus.intr_out}, 32'd1);

        // Withdraw by global disable, then a masked source that pends but stays silent.
        do_reset();
        irq = 4'h4; hold(4);
        gie = 1'b0; step();
        check("wd_intr", {31'd0, bus.intr_out}, 32'd0);
        check("wd_pend_kept", {31'd0, bus.pending[2]}, 32'd1);
        en = 4'b1011; gie = 1'b1; hold(3);
        check("mask_no_req", {31'd0, bus.intr_out}, 32'd0);
        en = 4'hF; step();
        check("unmask_req", {31'd0, bus.intr_out}, 32'd1);
        check("unmask_cause", {30'd0, bus.cause_id}, 32'd2);

        // Edge on source 1 coinciding with a software clear.
        do_reset();
        gie = 1'b0;
        irq = 4'h2; hold(3);
        irq = 4'h0; hold(3);
        irq = 4'h2; hold(2);
        clr = 4'h2; step(); clr = 4'h0;
        check("coll_swclr_pend1", {31'd0, bus.pending[1]}, 32'd1);
        clr = 4'h2; step(); clr = 4'h0;
        check("swclr_pend1", {31'd0, bus.pending[1]}, 32'd0);

        // Edge on source 1 coinciding with its own acceptance.
        do_reset();
        gie = 1'b1;
        irq = 4'h2; hold(4);
        irq = 4'h0; hold(3);
        irq = 4'h2; hold(2);
        taken = 1'b1; step(); taken = 1'b0;
        check("coll_win_state", {31'd0, bus.cause_valid}, 32'd1);
        check("coll_win_pend1", {31'd0, bus.pending[1]}, 32'd1);

        // Reset while in service.
        rstn = 1'b0; step(); rstn = 1'b1;
        check("svc_rst_valid", {31'd0, bus.cause_valid}, 32'd0);
        check("svc_rst_pend", {28'd0, bus.pending}, 32'd0);
        step();
        check("svc_rst_idle", {31'd0, bus.intr_out}, 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            rstn = ($urandom_range(0, 99) != 0);
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
            en    = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
            gie   = ($urandom_range(0, 9) != 0);
            clr   = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'h0;
            taken = ($urandom_range(0, 2) == 0);
            mret  = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
